vector_sequencer_control_unit: RTL and testbench

//  Parametrised successor to the single-cycle control unit. Scalar data-processing, memory and

---
 rtl/vec_ctrl_pkg.sv | 32 +++
 rtl/scalar_main_decoder.sv | 95 +++++++++
 rtl/vector_sequencer_control_unit.sv | 198 +++++++++++++++++++
 tb/tb_vector_sequencer_control_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vec_ctrl_pkg.sv
// ============================================================================
// vec_ctrl_pkg : shared encodings for the vector sequencer control unit
// Revision 1.0
// ============================================================================
`default_nettype none

package vec_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DOT  = 2'd2,
    WB   = 2'd3
  } seq_state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_VEC = 2'b11;

  localparam logic [3:0] VSUB_DOT = 4'd1;
  localparam logic [3:0] VSUB_MUV = 4'd2;
  localparam logic [3:0] VSUB_LDV = 4'd3;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/scalar_main_decoder.sv
// ============================================================================
// scalar_main_decoder : single-cycle main + ALU decode for scalar instructions
// Revision 1.0
// ============================================================================
`default_nettype none

module scalar_main_decoder
  import vec_ctrl_pkg::*;
(
  input  logic       en_i,
  input  logic [1:0] Op_i,
  input  logic [5:0] Funct_i,
  input  logic [3:0] Rd_i,
  output logic [1:0] RegSrc_o,
  output logic [1:0] ImmSrc_o,
  output logic [1:0] ALUControl_o,
  output logic [1:0] FlagW_o,
  output logic       ALUSrc_o,
  output logic       MemtoReg_o,
  output logic       RegW_o,
  output logic       MemW_o,
  output logic       Branch_o,
  output logic       link_o,
  output logic       NoWrite_o,
  output logic       PCS_o
);

  logic alu_op;

  always_comb begin
    RegSrc_o     = 2'b00;
    ImmSrc_o     = 2'b00;
    ALUControl_o = ALU_ADD;
    FlagW_o      = 2'b00;
    ALUSrc_o     = 1'b0;
    MemtoReg_o   = 1'b0;
    RegW_o       = 1'b0;
    MemW_o       = 1'b0;
    Branch_o     = 1'b0;
    link_o       = 1'b0;
    NoWrite_o    = 1'b0;
    alu_op       = 1'b0;

    if (en_i) begin
      case (Op_i)
        OP_DP: begin
          RegW_o   = 1'b1;
          ALUSrc_o = Funct_i[5];
          alu_op   = 1'b1;
        end
        OP_MEM: begin
          ImmSrc_o = 2'b01;
          ALUSrc_o = 1'b1;
          if (Funct_i[0]) begin
            MemtoReg_o = 1'b1;
            RegW_o     = 1'b1;
          end else begin
            RegSrc_o = 2'b10;
            MemW_o   = 1'b1;
          end
        end
        OP_BR: begin
          RegSrc_o = 2'b01;
          ImmSrc_o = 2'b10;
          ALUSrc_o = 1'b1;
          Branch_o = 1'b1;
          link_o   = Funct_i[4];
        end
        default: ;
      endcase
    end

    if (alu_op) begin
      case (Funct_i[4:1])
        4'b0100: ALUControl_o = ALU_ADD;
        4'b0010: ALUControl_o = ALU_SUB;
        4'b0000: ALUControl_o = ALU_AND;
        4'b1100: ALUControl_o = ALU_ORR;
        4'b1010: begin
          ALUControl_o = ALU_SUB;
          NoWrite_o    = 1'b1;
        end
        default: ALUControl_o = ALU_ADD;
      endcase
      // Only arithmetic ops update the carry/overflow half of the flags
      FlagW_o = {Funct_i[0],
                 Funct_i[0] & ((ALUControl_o == ALU_ADD) | (ALUControl_o == ALU_SUB))};
    end

    PCS_o = (Rd_i == 4'hF) & RegW_o;
  end

endmodule

`default_nettype wire

// File: rtl/vector_sequencer_control_unit.sv
// ============================================================================
// vector_sequencer_control_unit : scalar decode plus lane-by-lane DOT/LDV/STV sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module vector_sequencer_control_unit
  import vec_ctrl_pkg::*;
#(
  parameter  int LANES = 4,
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             instr_valid_i,
  input  logic             cond_ex_i,
  input  logic [1:0]       Op_i,
  input  logic [5:0]       Funct_i,
  input  logic [3:0]       Rd_i,
  input  logic             IndexSelect_i,
  input  logic             mem_ack_i,
  output logic [1:0]       RegSrc_o,
  output logic [1:0]       ImmSrc_o,
  output logic [1:0]       ALUControl_o,
  output logic [1:0]       FlagW_o,
  output logic             ALUSrc_o,
  output logic             MemtoReg_o,
  output logic             RegW_o,
  output logic             MemW_o,
  output logic             Branch_o,
  output logic             link_o,
  output logic             NoWrite_o,
  output logic             PCS_o,
  output logic             IndexReg_o,
  output logic             isDot_o,
  output logic             MemWriteV_o,
  output logic             RegWriteV_o,
  output logic             RegWriteVV_o,
  output logic             mem_req_o,
  output logic [IDX_W-1:0] lane_idx_o,
  output logic             dot_acc_clr_o,
  output logic             dot_acc_en_o,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] lane_q, lane_d;
  logic             is_ldv_q, is_ldv_d;
  logic             idx_sel_q, idx_sel_d;

  logic [3:0] sub_op;
  logic       vec_go, start_dot, start_mem, muv;
  logic       muv_alusrc, muv_regsrc0;
  logic       dec_alusrc;
  logic [1:0] dec_regsrc;

  assign sub_op    = Funct_i[4:1];
  assign vec_go    = instr_valid_i & cond_ex_i & (Op_i == OP_VEC) & (state_q == IDLE);
  assign start_dot = vec_go & (sub_op == VSUB_DOT);
  assign muv       = vec_go & (sub_op == VSUB_MUV);
  assign start_mem = vec_go & (sub_op != VSUB_DOT) & (sub_op != VSUB_MUV);

  scalar_main_decoder u_dec (
    .en_i         (instr_valid_i & (state_q == IDLE) & ~reset_i),
    .Op_i         (Op_i),
    .Funct_i      (Funct_i),
    .Rd_i         (Rd_i),
    .RegSrc_o     (dec_regsrc),
    .ImmSrc_o     (ImmSrc_o),
    .ALUControl_o (ALUControl_o),
    .FlagW_o      (FlagW_o),
    .ALUSrc_o     (dec_alusrc),
    .MemtoReg_o   (MemtoReg_o),
    .RegW_o       (RegW_o),
    .MemW_o       (MemW_o),
    .Branch_o     (Branch_o),
    .link_o       (link_o),
    .NoWrite_o    (NoWrite_o),
    .PCS_o        (PCS_o)
  );

  assign ALUSrc_o   = dec_alusrc | muv_alusrc;
  assign RegSrc_o   = dec_regsrc | {1'b0, muv_regsrc0};
  assign lane_idx_o = reset_i ? '0 : lane_q;
  assign busy_o     = (state_q != IDLE) & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      is_ldv_q  <= 1'b0;
      idx_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      is_ldv_q  <= is_ldv_d;
      idx_sel_q <= idx_sel_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    is_ldv_d      = is_ldv_q;
    idx_sel_d     = idx_sel_q;
    IndexReg_o    = 1'b0;
    isDot_o       = 1'b0;
    MemWriteV_o   = 1'b0;
    RegWriteV_o   = 1'b0;
    RegWriteVV_o  = 1'b0;
    mem_req_o     = 1'b0;
    dot_acc_clr_o = 1'b0;
    dot_acc_en_o  = 1'b0;
    stall_o       = 1'b0;
    done_o        = 1'b0;
    muv_alusrc    = 1'b0;
    muv_regsrc0   = 1'b0;

    case (state_q)
      IDLE: begin
        lane_d = '0;
        if (start_mem) begin
          state_d  = MEM;
          is_ldv_d = (sub_op == VSUB_LDV);
          stall_o  = 1'b1;
        end else if (start_dot) begin
          state_d       = DOT;
          idx_sel_d     = IndexSelect_i;
          IndexReg_o    = IndexSelect_i;
          dot_acc_clr_o = 1'b1;
          stall_o       = 1'b1;
        end else if (muv) begin
          RegWriteV_o = 1'b1;
          muv_alusrc  = Funct_i[5];
          muv_regsrc0 = 1'b1;
        end
      end
      MEM: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_ack_i) begin
          RegWriteVV_o = is_ldv_q;
          MemWriteV_o  = ~is_ldv_q;
          if (lane_q == LAST_LANE) begin
            state_d = IDLE;
            lane_d  = '0;
            done_o  = 1'b1;
            stall_o = 1'b0;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      DOT: begin
        isDot_o      = 1'b1;
        dot_acc_en_o = 1'b1;
        IndexReg_o   = idx_sel_q;
        stall_o      = 1'b1;
        if (lane_q == LAST_LANE) begin
          state_d = WB;
          lane_d  = '0;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      WB: begin
        RegWriteV_o = 1'b1;
        IndexReg_o  = idx_sel_q;
        done_o      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Quiet every sequencer output while reset is held, even mid-sequence
    if (reset_i) begin
      IndexReg_o    = 1'b0;
      isDot_o       = 1'b0;
      MemWriteV_o   = 1'b0;
      RegWriteV_o   = 1'b0;
      RegWriteVV_o  = 1'b0;
      mem_req_o     = 1'b0;
      dot_acc_clr_o = 1'b0;
      dot_acc_en_o  = 1'b0;
      stall_o       = 1'b0;
      done_o        = 1'b0;
      muv_alusrc    = 1'b0;
      muv_regsrc0   = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_sequencer_control_unit.sv
// ============================================================================
// tb_vector_sequencer_control_unit : directed scoreboard bench, LANES=4
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vector_sequencer_control_unit;

  typedef struct packed {
    logic [1:0] RegSrc;
    logic [1:0] ImmSrc;
    logic [1:0] ALUControl;
    logic [1:0] FlagW;
    logic       ALUSrc, MemtoReg, RegW, MemW, Branch, link, NoWrite, PCS;
    logic       IndexReg, isDot, MemWriteV, RegWriteV, RegWriteVV;
    logic       mem_req;
    logic [1:0] lane_idx;
    logic       dot_acc_clr, dot_acc_en, stall, busy, done;
  } outv_t;

  logic       clk, reset, instr_valid, cond_ex, IndexSelect, mem_ack;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [1:0] RegSrc, ImmSrc, ALUControl, FlagW, lane_idx;
  logic       ALUSrc, MemtoReg, RegW, MemW, Branch, link, NoWrite, PCS;
  logic       IndexReg, isDot, MemWriteV, RegWriteV, RegWriteVV;
  logic       mem_req, dot_acc_clr, dot_acc_en, stall, busy, done;

  outv_t act;
  outv_t sb_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  vector_sequencer_control_unit #(.LANES(4)) dut (
    .clk_i(clk), .reset_i(reset), .instr_valid_i(instr_valid), .cond_ex_i(cond_ex),
    .Op_i(Op), .Funct_i(Funct), .Rd_i(Rd), .IndexSelect_i(IndexSelect), .mem_ack_i(mem_ack),
    .RegSrc_o(RegSrc), .ImmSrc_o(ImmSrc), .ALUControl_o(ALUControl), .FlagW_o(FlagW),
    .ALUSrc_o(ALUSrc), .MemtoReg_o(MemtoReg), .RegW_o(RegW), .MemW_o(MemW),
    .Branch_o(Branch), .link_o(link), .NoWrite_o(NoWrite), .PCS_o(PCS),
    .IndexReg_o(IndexReg), .isDot_o(isDot), .MemWriteV_o(MemWriteV),
    .RegWriteV_o(RegWriteV), .RegWriteVV_o(RegWriteVV), .mem_req_o(mem_req),
    .lane_idx_o(lane_idx), .dot_acc_clr_o(dot_acc_clr), .dot_acc_en_o(dot_acc_en),
    .stall_o(stall), .busy_o(busy), .done_o(done)
  );

  assign act = {RegSrc, ImmSrc, ALUControl, FlagW,
                ALUSrc, MemtoReg, RegW, MemW, Branch, link, NoWrite, PCS,
                IndexReg, isDot, MemWriteV, RegWriteV, RegWriteVV,
                mem_req, lane_idx, dot_acc_clr, dot_acc_en, stall, busy, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outv_t sc(input logic [1:0] rs, input logic [1:0] is,
                               input logic [1:0] alu, input logic [1:0] fw,
                               input logic asrc, input logic m2r, input logic rw,
                               input logic mw, input logic br, input logic lk,
                               input logic nw, input logic pcs);
    outv_t e = '0;
    e.RegSrc = rs; e.ImmSrc = is; e.ALUControl = alu; e.FlagW = fw;
    e.ALUSrc = asrc; e.MemtoReg = m2r; e.RegW = rw; e.MemW = mw;
    e.Branch = br; e.link = lk; e.NoWrite = nw; e.PCS = pcs;
    return e;
  endfunction

  function automatic outv_t vc(input logic ir, input logic dt, input logic mwv,
                               input logic rwv, input logic rwvv, input logic req,
                               input logic [1:0] ln, input logic clr, input logic en,
                               input logic st, input logic bz, input logic dn);
    outv_t e = '0;
    e.IndexReg = ir; e.isDot = dt; e.MemWriteV = mwv; e.RegWriteV = rwv;
    e.RegWriteVV = rwvv; e.mem_req = req; e.lane_idx = ln; e.dot_acc_clr = clr;
    e.dot_acc_en = en; e.stall = st; e.busy = bz; e.done = dn;
    return e;
  endfunction

  task automatic set(input logic v, input logic c, input logic [1:0] op,
                     input logic [5:0] f, input logic [3:0] rd,
                     input logic isel, input logic ack);
    instr_valid = v; cond_ex = c; Op = op; Funct = f; Rd = rd;
    IndexSelect = isel; mem_ack = ack;
  endtask

  // Expectation enters the scoreboard with the stimulus and leaves at the mid-cycle sample
  task automatic chk(input string tag, input outv_t e);
    outv_t x;
    sb_q.push_back(e);
    vectors++;
    @(negedge clk);
    x = sb_q.pop_front();
    assert (act === x) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, act, x);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    outv_t e;
    reset = 1'b1;
    set(1'b1, 1'b1, 2'b00, 6'b101001, 4'd3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset0", '0);
    chk("reset1", '0);
    reset = 1'b0;

    chk("add_s", sc(2'b00, 2'b00, 2'b00, 2'b11, 1, 0, 1, 0, 0, 0, 0, 0));
    set(1, 1, 2'b00, 6'b000100, 4'hF, 0, 0);
    chk("sub_pcs", sc(2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 1));
    set(1, 1, 2'b00, 6'b010101, 4'd3, 0, 0);
    chk("cmp", sc(2'b00, 2'b00, 2'b01, 2'b11, 0, 0, 1, 0, 0, 0, 1, 0));
    set(1, 1, 2'b00, 6'b011001, 4'd3, 0, 0);
    chk("orr_s", sc(2'b00, 2'b00, 2'b11, 2'b10, 0, 0, 1, 0, 0, 0, 0, 0));
    set(1, 1, 2'b01, 6'b000000, 4'd3, 0, 0);
    chk("str", sc(2'b10, 2'b01, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0));
    set(1, 1, 2'b10, 6'b010000, 4'd3, 0, 0);
    chk("bl", sc(2'b01, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, 1, 1, 0, 0));
    set(0, 1, 2'b00, 6'b101001, 4'd3, 0, 0);
    chk("invalid", '0);

    set(1, 1, 2'b11, 6'b100100, 4'd3, 0, 0);
    e = vc(0, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    e.ALUSrc = 1'b1;
    e.RegSrc = 2'b01;
    chk("muv", e);

    // LDV with ack every cycle, followed by a held LDR
    set(1, 1, 2'b11, 6'b000110, 4'd3, 0, 1);
    chk("ldv_start", vc(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 4; k++) begin
      if (k == 1) Op = 2'b00;
      chk($sformatf("ldv_lane%0d", k),
          vc(0, 0, 0, 0, 1, 1, 2'(k), 0, 0, k != 3, 1, k == 3));
    end
    set(1, 1, 2'b01, 6'b000001, 4'd3, 0, 0);
    chk("ldr_after", sc(2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0, 0));

    // STV with a three-cycle ack gap on lane 1
    set(1, 1, 2'b11, 6'b001000, 4'd3, 0, 1);
    chk("stv_start", vc(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0));
    chk("stv_lane0", vc(0, 0, 1, 0, 0, 1, 2'd0, 0, 0, 1, 1, 0));
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++)
      chk($sformatf("stv_wait%0d", k), vc(0, 0, 0, 0, 0, 1, 2'd1, 0, 0, 1, 1, 0));
    mem_ack = 1'b1;
    chk("stv_lane1", vc(0, 0, 1, 0, 0, 1, 2'd1, 0, 0, 1, 1, 0));
    chk("stv_lane2", vc(0, 0, 1, 0, 0, 1, 2'd2, 0, 0, 1, 1, 0));
    chk("stv_lane3", vc(0, 0, 1, 0, 0, 1, 2'd3, 0, 0, 0, 1, 1));
    set(0, 1, 2'b11, 6'b001000, 4'd3, 0, 0);
    chk("stv_idle", '0);

    // DOT with register index; later IndexSelect changes must be ignored
    set(1, 1, 2'b11, 6'b000010, 4'd3, 1, 0);
    chk("dot_start", vc(1, 0, 0, 0, 0, 0, 2'd0, 1, 0, 1, 0, 0));
    IndexSelect = 1'b0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("dot_lane%0d", k), vc(1, 1, 0, 0, 0, 0, 2'(k), 0, 1, 1, 1, 0));
    chk("dot_wb", vc(1, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 1, 1));
    set(0, 1, 2'b11, 6'b000010, 4'd3, 0, 0);
    chk("dot_idle", '0);

    // Reset while MEM sits at lane 2, then a late ack
    set(1, 1, 2'b11, 6'b000110, 4'd3, 0, 1);
    chk("rldv_start", vc(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0));
    chk("rldv_lane0", vc(0, 0, 0, 0, 1, 1, 2'd0, 0, 0, 1, 1, 0));
    chk("rldv_lane1", vc(0, 0, 0, 0, 1, 1, 2'd1, 0, 0, 1, 1, 0));
    reset = 1'b1;
    chk("rst_mid", '0);
    reset = 1'b0;
    set(0, 1, 2'b11, 6'b000110, 4'd3, 0, 1);
    chk("rst_after", '0);

    // Vector ops with failed condition never start
    set(1, 0, 2'b11, 6'b000110, 4'd3, 0, 1);
    chk("ldv_nocond0", '0);
    chk("ldv_nocond1", '0);
    set(1, 0, 2'b11, 6'b000010, 4'd3, 1, 0);
    chk("dot_nocond", '0);
    set(1, 0, 2'b11, 6'b100100, 4'd3, 0, 0);
    chk("muv_nocond", '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
